inst_mem_arbiter: RTL

//  Shares one single-port synchronous instruction SRAM between the CPU fetch port and a boot/debug

---
 rtl/inst_mem_arbiter.sv | 98 +++++++++
 1 files changed

// File: rtl/inst_mem_arbiter.sv
// Arbitrates one single-port synchronous instruction SRAM between CPU fetch and a program loader.
// Define INST_ARB_BOOT_EN to start in a loader-only BOOT phase; otherwise reset enters RUN directly.
module inst_mem_arbiter #(
  parameter int unsigned DATA_W     = 16,
  parameter int unsigned ADDR_W     = 16,
  parameter int unsigned MAX_LD_RUN = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cpu_ce_i,
  input  logic [ADDR_W-1:0] cpu_addr_i,
  output logic [DATA_W-1:0] cpu_data_o,
  output logic              cpu_valid_o,
  output logic              cpu_stall_o,
  input  logic              ld_valid_i,
  input  logic [ADDR_W-1:0] ld_addr_i,
  input  logic [DATA_W-1:0] ld_data_i,
  output logic              ld_ready_o,
  input  logic              ld_done_i,
  output logic              boot_o,
  output logic              mem_ce_o,
  output logic              mem_we_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [DATA_W-1:0] mem_wdata_o,
  input  logic [DATA_W-1:0] mem_rdata_i
);

  localparam int unsigned     CntW   = $clog2(MAX_LD_RUN + 1);
  localparam logic [CntW-1:0] CntMax = CntW'(MAX_LD_RUN);

  logic              w_boot;
  logic              w_cpu_capped;
  logic              w_ld_gnt;
  logic              w_cpu_gnt;
  logic [CntW-1:0]   r_run_cnt;
  logic              r_rd_pend;
  logic [DATA_W-1:0] r_data;

`ifdef INST_ARB_BOOT_EN
  typedef enum logic {StBoot, StRun} state_e;
  state_e r_state;
  logic   r_boot;

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state <= StBoot;
      r_boot  <= 1'b1;
    end else if (r_state == StBoot && ld_done_i) begin
      r_state <= StRun;
      r_boot  <= 1'b0;
    end
  end

  assign w_boot = r_boot;
`else
  logic w_unused_done;
  assign w_unused_done = ld_done_i;
  assign w_boot        = 1'b0;
`endif

  // Loader wins unless it has already held the CPU off for MAX_LD_RUN consecutive grants.
  assign w_cpu_capped = cpu_ce_i && (r_run_cnt == CntMax);
  assign w_ld_gnt     = rst && ld_valid_i && (w_boot || !w_cpu_capped);
  assign w_cpu_gnt    = rst && !w_boot && cpu_ce_i && !w_ld_gnt;

  always_ff @(posedge clk) begin
    if (!rst || w_boot || !cpu_ce_i || w_cpu_gnt) begin
      r_run_cnt <= '0;
    end else if (w_ld_gnt && r_run_cnt != CntMax) begin
      r_run_cnt <= r_run_cnt + CntW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_rd_pend <= 1'b0;
      r_data    <= '0;
    end else begin
      r_rd_pend <= w_cpu_gnt;
      if (r_rd_pend) begin
        r_data <= mem_rdata_i;
      end
    end
  end

  // SRAM read data is presented directly in the cycle after the grant, then held in r_data.
  assign cpu_data_o  = r_rd_pend ? mem_rdata_i : r_data;
  assign cpu_valid_o = r_rd_pend;
  assign cpu_stall_o = cpu_ce_i && !w_cpu_gnt;
  assign ld_ready_o  = w_ld_gnt;
  assign boot_o      = w_boot;

  assign mem_ce_o    = w_ld_gnt || w_cpu_gnt;
  assign mem_we_o    = w_ld_gnt;
  assign mem_addr_o  = w_ld_gnt ? ld_addr_i : (w_cpu_gnt ? cpu_addr_i : '0);
  assign mem_wdata_o = w_ld_gnt ? ld_data_i : '0;

endmodule
